multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_decode.sv | 33 +++
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared control encodings for the multicycle datapath: FSM states, mux selects,
// next-PC ops, ALU codes, opcode/funct values and the instruction-class record.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EXE = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    localparam logic [1:0] RD_RT      = 2'd0, RD_RD      = 2'd1, RD_RA   = 2'd2;
    localparam logic [1:0] ALUSRC_REG = 2'd0, ALUSRC_IMM = 2'd1, ALUSRC_SHA = 2'd2;
    localparam logic [1:0] ALU2REG    = 2'd0, DM2REG     = 2'd1, NPC2REG = 2'd2;
    localparam logic [1:0] NPC_PLUS4  = 2'd0, NPC_BRANCH = 2'd1, NPC_JUMP = 2'd2, NPC_JR = 2'd3;

    localparam logic [4:0] ALU_NOP = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_AND = 5'd3,
                           ALU_OR  = 5'd4, ALU_SLT = 5'd5, ALU_SLL = 5'd6, ALU_SRL = 5'd7,
                           ALU_LUI = 5'd8;

    localparam logic [5:0] OP_R   = 6'b000000, OP_LW  = 6'b100011, OP_SW  = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_J   = 6'b000010,
                           OP_JAL = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000, FN_ADDU = 6'b100001, FN_SUB = 6'b100010,
                           FN_SUBU = 6'b100011, FN_AND = 6'b100100, FN_OR  = 6'b100101,
                           FN_SLT = 6'b101010, FN_SLL = 6'b000000, FN_SRL = 6'b000010,
                           FN_JR  = 6'b001000;

    typedef struct packed {
        logic r, lw, sw, beq, bne, addi, ori, lui, j, jal, jr, shift, legal;
    } instr_class_t;

    function automatic logic [4:0] alu_decode(input logic is_r, input logic is_add,
                                              input logic is_ori, input logic is_lui,
                                              input logic is_br, input logic [5:0] fn);
        logic [4:0] op;
        op = ALU_NOP;
        if (is_add)      op = ALU_ADD;
        else if (is_ori) op = ALU_OR;
        else if (is_lui) op = ALU_LUI;
        else if (is_br)  op = ALU_SUB;
        else if (is_r) begin
            case (fn)
                FN_ADD, FN_ADDU: op = ALU_ADD;
                FN_SUB, FN_SUBU: op = ALU_SUB;
                FN_AND:          op = ALU_AND;
                FN_OR:           op = ALU_OR;
                FN_SLT:          op = ALU_SLT;
                FN_SLL:          op = ALU_SLL;
                FN_SRL:          op = ALU_SRL;
                default:         op = ALU_NOP;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/multicycle_decode.sv
// Opcode/funct to instruction-class flags plus the EXE-stage ALU code.
module multicycle_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic [4:0]   alu_code
);

    always_comb begin
        cls       = '0;
        cls.r     = (opcode == OP_R);
        cls.lw    = (opcode == OP_LW);
        cls.sw    = (opcode == OP_SW);
        cls.beq   = (opcode == OP_BEQ);
        cls.bne   = (opcode == OP_BNE);
        cls.addi  = (opcode == OP_ADDI);
        cls.ori   = (opcode == OP_ORI);
        cls.lui   = (opcode == OP_LUI);
        cls.j     = (opcode == OP_J);
        cls.jal   = (opcode == OP_JAL);
        cls.jr    = cls.r && (funct == FN_JR);
        cls.shift = cls.r && ((funct == FN_SLL) || (funct == FN_SRL));
        // any R-type funct is accepted here; unknown functs just get ALU_NOP
        cls.legal = cls.r | cls.lw | cls.sw | cls.beq | cls.bne | cls.addi |
                    cls.ori | cls.lui | cls.j | cls.jal;
    end

    assign alu_code = alu_decode(cls.r, cls.lw | cls.sw | cls.addi, cls.ori, cls.lui,
                                 cls.beq | cls.bne, funct);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM (IF/ID/EXE/MEM/WB) with retired-instruction counter.
// Define MEMWAIT_EN to add mem_rdy and stall IF/MEM on the shared memory.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
`ifdef MEMWAIT_EN
    input  logic        mem_rdy,
`endif
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_write,
    output logic        reg_write,
    output logic        IorD,
    output logic        ALUSrc0,
    output logic [1:0]  RegDst,
    output logic [1:0]  ALUSrc,
    output logic [1:0]  ToReg,
    output logic [1:0]  NPCOp,
    output logic [4:0]  alu_op,
    output logic [2:0]  state,
    output logic        illegal,
    output logic [31:0] instr_cnt
);

    instr_class_t cls;
    logic [4:0]   alu_code;
    logic [2:0]   state_q, state_d;
    logic [31:0]  instr_cnt_q, cnt_d;
    logic         mem_ok, retire;

`ifdef MEMWAIT_EN
    assign mem_ok = mem_rdy;
`else
    assign mem_ok = 1'b1;
`endif

    multicycle_decode u_dec (
        .opcode   (opcode),
        .funct    (funct),
        .cls      (cls),
        .alu_code (alu_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IF;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = ST_IF;
        case (state_q)
            ST_IF:  state_d = mem_ok ? ST_ID : ST_IF;
            ST_ID:  state_d = (cls.j || cls.jal || !cls.legal) ? ST_IF : ST_EXE;
            ST_EXE: begin
                if (cls.beq || cls.bne || cls.jr) state_d = ST_IF;
                else if (cls.lw || cls.sw)        state_d = ST_MEM;
                else                              state_d = ST_WB;
            end
            ST_MEM: begin
                if (!mem_ok)     state_d = ST_MEM;
                else if (cls.lw) state_d = ST_WB;
                else             state_d = ST_IF;
            end
            ST_WB:   state_d = ST_IF;
            default: state_d = ST_IF;
        endcase
    end

    // unused codes 5-7 fall back to IF without counting a retire
    assign retire = (state_q != ST_IF) && (state_q <= ST_WB) && (state_d == ST_IF);
    assign cnt_d  = instr_cnt_q + {31'd0, retire};

    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        IorD      = 1'b0;
        ALUSrc0   = 1'b0;
        RegDst    = RD_RT;
        ALUSrc    = ALUSRC_REG;
        ToReg     = ALU2REG;
        NPCOp     = NPC_PLUS4;
        alu_op    = ALU_NOP;
        case (state_q)
            ST_IF: begin
                ir_write = mem_ok;
                pc_write = mem_ok;
            end
            ST_ID: begin
                if (cls.j || cls.jal) begin
                    pc_write = 1'b1;
                    NPCOp    = NPC_JUMP;
                end
                if (cls.jal) begin
                    reg_write = 1'b1;
                    RegDst    = RD_RA;
                    ToReg     = NPC2REG;
                end
                illegal = !cls.legal;
            end
            ST_EXE: begin
                alu_op = alu_code;
                if (cls.beq || cls.bne) begin
                    pc_write = cls.beq ? zero : !zero;
                    NPCOp    = NPC_BRANCH;
                end
                if (cls.jr) begin
                    pc_write = 1'b1;
                    NPCOp    = NPC_JR;
                end
                if (cls.shift) begin
                    ALUSrc  = ALUSRC_SHA;
                    ALUSrc0 = 1'b1;
                end
                if (cls.lw || cls.sw || cls.addi || cls.ori || cls.lui)
                    ALUSrc = ALUSRC_IMM;
            end
            ST_MEM: begin
                IorD      = 1'b1;
                mem_write = cls.sw;
            end
            ST_WB: begin
                reg_write = 1'b1;
                RegDst    = cls.r ? RD_RD : RD_RT;
                ToReg     = cls.lw ? DM2REG : ALU2REG;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle control word; one process compares.
module tb_multicycle_ctrl;

    typedef enum int {K_R, K_SHIFT, K_JR, K_LW, K_SW, K_BEQ, K_BNE, K_IMM, K_J, K_JAL, K_BAD} kind_e;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        kind_e      k;
        logic [4:0] alu;
        logic       z;
    } vec_t;

    typedef struct {
        logic [22:0] v;
        logic [31:0] cnt;
        int          ph;
    } rec_t;

    logic        clk, rst, zero, mem_rdy;
    logic [5:0]  opcode, funct;
    logic        pc_write, ir_write, mem_write, reg_write, IorD, ALUSrc0, illegal;
    logic [1:0]  RegDst, ALUSrc, ToReg, NPCOp;
    logic [4:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] instr_cnt;
    logic [22:0] obs;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] model_cnt = 0;
    rec_t exp_q[$];

    multicycle_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
`ifdef MEMWAIT_EN
        .mem_rdy   (mem_rdy),
`endif
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .mem_write (mem_write),
        .reg_write (reg_write),
        .IorD      (IorD),
        .ALUSrc0   (ALUSrc0),
        .RegDst    (RegDst),
        .ALUSrc    (ALUSrc),
        .ToReg     (ToReg),
        .NPCOp     (NPCOp),
        .alu_op    (alu_op),
        .state     (state),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    assign obs = {state, pc_write, ir_write, mem_write, reg_write, IorD, ALUSrc0,
                  RegDst, ALUSrc, ToReg, NPCOp, alu_op, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input kind_e k,
                                input logic [4:0] alu, input logic z);
        vec_t v;
        v.op = op; v.fn = fn; v.k = k; v.alu = alu; v.z = z;
        return v;
    endfunction

    // Control word an instruction of kind k must show in phase ph (0=IF..4=WB).
    function automatic logic [22:0] expect_word(input vec_t v, input int ph, input logic rdy,
                                                input logic in_rst);
        logic       pcw, irw, mw, rw, iord, src0, ill;
        logic [1:0] rdst, asrc, toreg, npc;
        logic [4:0] aop;
        {pcw, irw, mw, rw, iord, src0, ill} = '0;
        {rdst, asrc, toreg, npc} = '0;
        aop = 5'd0;
        case (ph)
            0: begin irw = rdy; pcw = rdy; end
            1: begin
                if (v.k == K_J)   begin pcw = 1; npc = 2'd2; end
                if (v.k == K_JAL) begin pcw = 1; npc = 2'd2; rw = 1; rdst = 2'd2; toreg = 2'd2; end
                if (v.k == K_BAD) ill = 1;
            end
            2: begin
                aop = v.alu;
                case (v.k)
                    K_BEQ:   begin pcw = v.z;  npc = 2'd1; end
                    K_BNE:   begin pcw = !v.z; npc = 2'd1; end
                    K_JR:    begin pcw = 1;    npc = 2'd3; end
                    K_SHIFT: begin asrc = 2'd2; src0 = 1; end
                    K_LW, K_SW, K_IMM: asrc = 2'd1;
                    default: ;
                endcase
            end
            3: begin iord = 1; mw = (v.k == K_SW); end
            4: begin
                rw    = 1;
                rdst  = (v.k == K_R || v.k == K_SHIFT) ? 2'd1 : 2'd0;
                toreg = (v.k == K_LW) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
        if (in_rst) {pcw, irw, mw, rw, ill} = '0;
        return {3'(ph), pcw, irw, mw, rw, iord, src0, rdst, asrc, toreg, npc, aop, ill};
    endfunction

    task automatic push(input logic [22:0] w, input int ph);
        rec_t r;
        r.v = w; r.cnt = model_cnt; r.ph = ph;
        exp_q.push_back(r);
    endtask

    // Drive one instruction; rst_ph aborts it by asserting reset in that phase.
    task automatic run(input vec_t v, input int ifw, input int memw, input int rst_ph,
                       input bit preload);
        int path[$];
        int reps;
        case (v.k)
            K_J, K_JAL, K_BAD:  path = '{0, 1};
            K_BEQ, K_BNE, K_JR: path = '{0, 1, 2};
            K_SW:               path = '{0, 1, 2, 3};
            K_LW:               path = '{0, 1, 2, 3, 4};
            default:            path = '{0, 1, 2, 4};
        endcase
        foreach (path[i]) begin
            reps = (path[i] == 0) ? ifw + 1 : (path[i] == 3) ? memw + 1 : 1;
            for (int r = 0; r < reps; r++) begin
                @(posedge clk); #1;
                opcode  = v.op;
                funct   = v.fn;
                zero    = v.z;
                mem_rdy = (r == reps - 1);
                rst     = (path[i] == rst_ph);
                if (preload && path[i] == 0) force dut.cnt_d = 32'hFFFF_FFFF;
                if (preload && path[i] == 1) begin
                    release dut.cnt_d;
                    model_cnt = 32'hFFFF_FFFF;
                end
                push(expect_word(v, path[i], mem_rdy, rst), path[i]);
                if (rst) begin
                    model_cnt = 0;
                    return;
                end
            end
        end
        model_cnt = model_cnt + 1;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    initial begin : compare
        rec_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (obs !== e.v || instr_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL ctrl_word phase %0d @%0t: got %h cnt %h, expected %h cnt %h",
                             e.ph, $time, obs, instr_cnt, e.v, e.cnt);
                end
            end
        end
    end

    initial begin : stim
        vec_t v_lw, v_sw, v_beq1, v_beq0, v_bne0, v_bne1, v_jal, v_j, v_bad;
        vec_t v_add, v_sub, v_or, v_slt, v_sll, v_srl, v_jr, v_addi, v_ori, v_lui;
        v_lw   = mk(6'b100011, 6'b000000, K_LW,    5'd1, 1'b0);
        v_sw   = mk(6'b101011, 6'b000000, K_SW,    5'd1, 1'b0);
        v_beq1 = mk(6'b000100, 6'b000000, K_BEQ,   5'd2, 1'b1);
        v_beq0 = mk(6'b000100, 6'b000000, K_BEQ,   5'd2, 1'b0);
        v_bne0 = mk(6'b000101, 6'b000000, K_BNE,   5'd2, 1'b0);
        v_bne1 = mk(6'b000101, 6'b000000, K_BNE,   5'd2, 1'b1);
        v_jal  = mk(6'b000011, 6'b000000, K_JAL,   5'd0, 1'b0);
        v_j    = mk(6'b000010, 6'b000000, K_J,     5'd0, 1'b0);
        v_bad  = mk(6'b111111, 6'b000000, K_BAD,   5'd0, 1'b0);
        v_add  = mk(6'b000000, 6'b100000, K_R,     5'd1, 1'b0);
        v_sub  = mk(6'b000000, 6'b100010, K_R,     5'd2, 1'b1);
        v_or   = mk(6'b000000, 6'b100101, K_R,     5'd4, 1'b0);
        v_slt  = mk(6'b000000, 6'b101010, K_R,     5'd5, 1'b0);
        v_sll  = mk(6'b000000, 6'b000000, K_SHIFT, 5'd6, 1'b0);
        v_srl  = mk(6'b000000, 6'b000010, K_SHIFT, 5'd7, 1'b0);
        v_jr   = mk(6'b000000, 6'b001000, K_JR,    5'd0, 1'b0);
        v_addi = mk(6'b001000, 6'b000000, K_IMM,   5'd1, 1'b0);
        v_ori  = mk(6'b001101, 6'b000000, K_IMM,   5'd4, 1'b0);
        v_lui  = mk(6'b001111, 6'b000000, K_IMM,   5'd8, 1'b0);

        // reset with an lw opcode present: IF strobes must stay low
        rst = 1'b1; opcode = 6'b100011; funct = '0; zero = 1'b0; mem_rdy = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            push(23'd0, 0);
        end

        run(v_lw, 0, 0, -1, 0);
        @(negedge clk); #1;
        lit("lw_wb_state", 32'(state), 32'd4);
        lit("lw_wb_toreg", 32'(ToReg), 32'd1);
        run(v_beq1, 0, 0, -1, 0);
        @(negedge clk); #1;
        lit("beq_taken_pcw", 32'(pc_write), 32'd1);
        lit("cnt_after_lw", instr_cnt, 32'd1);
        run(v_beq0, 0, 0, -1, 0);
        @(negedge clk); #1;
        lit("beq_nottaken_pcw", 32'(pc_write), 32'd0);
        run(v_jal, 0, 0, -1, 0);
        @(negedge clk); #1;
        lit("jal_id_word", {reg_write, RegDst, ToReg, pc_write}, {1'b1, 2'd2, 2'd2, 1'b1});
        run(v_bad, 0, 0, -1, 0);
        @(negedge clk); #1;
        lit("illegal_pulse", {illegal, reg_write, pc_write, mem_write}, 4'b1000);
        lit("cnt_before_bad", instr_cnt, 32'd4);

        run(v_add, 0, 0, -1, 0);  run(v_sub, 0, 0, -1, 0);  run(v_or, 0, 0, -1, 0);
        run(v_slt, 0, 0, -1, 0);  run(v_sll, 0, 0, -1, 0);  run(v_srl, 0, 0, -1, 0);
        run(v_jr, 0, 0, -1, 0);   run(v_addi, 0, 0, -1, 0); run(v_ori, 0, 0, -1, 0);
        run(v_lui, 0, 0, -1, 0);  run(v_j, 0, 0, -1, 0);    run(v_bne0, 0, 0, -1, 0);
        run(v_bne1, 0, 0, -1, 0); run(v_sw, 0, 0, -1, 0);   run(v_bad, 0, 0, -1, 0);

`ifdef MEMWAIT_EN
        run(v_sw, 0, 3, -1, 0);
        @(negedge clk); #1;
        lit("sw_wait_memwrite", 32'(mem_write), 32'd1);
        run(v_lw, 2, 2, -1, 0);
        run(v_add, 1, 0, -1, 0);
`endif

        // reset during sw MEM: no write, counter cleared
        run(v_sw, 0, 0, 3, 0);
        @(negedge clk); #1;
        lit("rst_mem_memwrite", 32'(mem_write), 32'd0);
        run(v_j, 0, 0, -1, 1);
        @(negedge clk); #1;
        lit("preload_cnt", instr_cnt, 32'hFFFF_FFFF);
        run(v_lw, 0, 0, -1, 0);
        @(negedge clk); #1;
        lit("wrap_cnt", instr_cnt, 32'd0);
        lit("lw2_wb_regwrite", 32'(reg_write), 32'd1);

        repeat (3) @(negedge clk);
        #1;
        lit("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
